// File: rtl/seq_packer.sv
// seq_packer: packs a 2-bit nucleotide stream into 32-bit words (16 bases, LSB-first) behind a small FIFO.
// Optional per-nucleotide statistics are compiled in with `define SEQ_PACKER_STATS_EN.

`ifdef SEQ_PACKER_STATS_EN
module seq_stat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (inc && ~&cnt)   cnt <= cnt + 1'b1;
  end
endmodule
`endif

module seq_packer #(
  parameter int SEQ_LEN_W  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SEQ_LEN_W-1:0] seq_len,
  input  logic                 base_valid,
  input  logic [1:0]           base,
  output logic                 base_ready,
  output logic [31:0]          word_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 word_last,
  output logic [4:0]           word_nbases,
  output logic                 busy,
  output logic                 done,
  output logic [SEQ_LEN_W-1:0] cnt_a,
  output logic [SEQ_LEN_W-1:0] cnt_c,
  output logic [SEQ_LEN_W-1:0] cnt_g,
  output logic [SEQ_LEN_W-1:0] cnt_t
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [SEQ_LEN_W-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [4:0]  nbases;
  } word_t;

  state_t state, state_nx;

  logic [SEQ_LEN_W-1:0] len_q, base_cnt;
  logic [3:0]           lane;
  logic [31:0]          part;

  word_t         mem [FIFO_DEPTH];
  word_t         head, push_word;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, accept, final_base, start_ok;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign start_ok   = (state == IDLE) && start;
  assign accept     = base_valid && base_ready;
  assign final_base = (base_cnt == len_q - ONE);
  assign push       = accept && ((lane == 4'hF) || final_base);
  assign pop        = word_valid && word_ready;
  assign head       = mem[rd_ptr];

  // Incoming base lands on top of the accumulated partial word; upper bits stay zero.
  always_comb begin
    push_word.data   = part | (32'(base) << {lane, 1'b0});
    push_word.last   = final_base;
    push_word.nbases = {1'b0, lane} + 5'd1;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (seq_len != '0) ? PACK : DONE;
      PACK:    if (accept && final_base) state_nx = DRAIN;
      DRAIN:   if (pop && head.last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs; base_ready deliberately ignores pop so word_ready never reaches it
  always_comb begin
    base_ready = (state == PACK) && !full;
    busy       = (state == PACK) || (state == DRAIN);
    done       = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q    <= '0;
      base_cnt <= '0;
      lane     <= '0;
      part     <= '0;
    end else if (start_ok) begin
      len_q    <= seq_len;
      base_cnt <= '0;
      lane     <= '0;
      part     <= '0;
    end else if (accept) begin
      base_cnt <= base_cnt + ONE;
      lane     <= lane + 4'd1;
      part     <= push ? '0 : push_word.data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head fields are gated so stale storage never shows while empty or in reset.
  assign word_valid  = !empty;
  assign word_data   = word_valid ? head.data   : '0;
  assign word_last   = word_valid ? head.last   : 1'b0;
  assign word_nbases = word_valid ? head.nbases : '0;

`ifdef SEQ_PACKER_STATS_EN
  logic [3:0][SEQ_LEN_W-1:0] cnt;
  for (genvar i = 0; i < 4; i++) begin : g_stat
    seq_stat_cnt #(.W(SEQ_LEN_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (start_ok),
      .inc   (accept && (base == 2'(i))),
      .cnt   (cnt[i])
    );
  end
  assign cnt_a = cnt[0];
  assign cnt_c = cnt[1];
  assign cnt_g = cnt[2];
  assign cnt_t = cnt[3];
`else
  assign cnt_a = '0;
  assign cnt_c = '0;
  assign cnt_g = '0;
  assign cnt_t = '0;
`endif

endmodule

// File: tb/tb_seq_packer.sv
// Directed, table-driven bench for seq_packer; stats expectations follow SEQ_PACKER_STATS_EN.
module tb_seq_packer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic [15:0] seq_len = '0;
  logic        base_valid = 1'b0;
  logic [1:0]  base = '0;
  logic        base_ready;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        word_last;
  logic [4:0]  word_nbases;
  logic        busy, done;
  logic [15:0] cnt_a, cnt_c, cnt_g, cnt_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_packer #(.SEQ_LEN_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .seq_len(seq_len),
    .base_valid(base_valid), .base(base), .base_ready(base_ready),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .word_last(word_last), .word_nbases(word_nbases), .busy(busy), .done(done),
    .cnt_a(cnt_a), .cnt_c(cnt_c), .cnt_g(cnt_g), .cnt_t(cnt_t)
  );

  typedef struct {
    int len, mode, hold, stall, nw, last_nb;
    logic [4:0][31:0] words;
    int ca, cc, cg, ct;
  } vec_t;

  vec_t tab [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] base_of(input int mode, input int i);
    case (mode)
      0:       return 2'(i % 4);
      1:       return 2'd3;
      2:       return (i < 8) ? 2'd0 : (i < 12) ? 2'd1 : (i < 16) ? 2'd2 : 2'd3;
      default: return 2'(((i / 16) + 1) % 4);
    endcase
  endfunction

  function automatic vec_t mk(input int len, mode, hold, stall, nw, last_nb,
                              input logic [31:0] w0, w1, w2, w3, w4,
                              input int ca, cc, cg, ct);
    vec_t v;
    v.len = len; v.mode = mode; v.hold = hold; v.stall = stall;
    v.nw = nw; v.last_nb = last_nb; v.words = {w4, w3, w2, w1, w0};
    v.ca = ca; v.cc = cc; v.cg = cg; v.ct = ct;
    return v;
  endfunction

  task automatic run_seq(input vec_t v);
    int idx = 0, nw = 0, ndone = 0;
    @(posedge clk); #1;
    start = 1'b1; seq_len = 16'(v.len); base_valid = 1'b0; word_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    base_valid = (idx < v.len); base = base_of(v.mode, idx);
    word_ready = (v.hold == 0);
    for (int cyc = 0; cyc < 600 && ndone == 0; cyc++) begin
      @(negedge clk);
      if (v.hold > 0 && cyc == v.hold - 1) begin
        chk("stall_bases", 64'(idx), 64'(v.stall));
        chk("stall_base_ready", 64'(base_ready), 64'd0);
        chk("stall_word_valid", 64'(word_valid), 64'd1);
      end
      if (word_valid && word_ready) begin
        if (nw < 5) chk("word_data", 64'(word_data), 64'(v.words[nw]));
        chk("word_nbases", 64'(word_nbases), 64'((nw == v.nw - 1) ? v.last_nb : 16));
        chk("word_last", 64'(word_last), 64'(nw == v.nw - 1));
        nw++;
      end
      if (base_valid && base_ready) idx++;
      if (done) begin
        ndone++;
`ifdef SEQ_PACKER_STATS_EN
        chk("cnt_acgt", {cnt_a, cnt_c, cnt_g, cnt_t},
            {16'(v.ca), 16'(v.cc), 16'(v.cg), 16'(v.ct)});
`else
        chk("cnt_acgt", {cnt_a, cnt_c, cnt_g, cnt_t}, 64'd0);
`endif
      end
      @(posedge clk); #1;
      base_valid = (idx < v.len); base = base_of(v.mode, idx);
      word_ready = (cyc + 1 >= v.hold);
    end
    chk("done_seen", 64'(ndone), 64'd1);
    chk("words_popped", 64'(nw), 64'(v.nw));
    chk("bases_taken", 64'(idx), 64'(v.len));
    @(negedge clk);
    chk("done_single", 64'({done, busy}), 64'd0);
  endtask

  initial begin
    int idx, done_at, nvalid, nbusy;
    tab[0] = mk(16, 0, 0,  0, 1, 16, 32'hE4E4E4E4, 0, 0, 0, 0, 4, 4, 4, 4);
    tab[1] = mk( 5, 1, 0,  0, 1,  5, 32'h000003FF, 0, 0, 0, 0, 0, 0, 0, 5);
    tab[2] = mk(20, 2, 0,  0, 2,  4, 32'hAA550000, 32'h000000FF, 0, 0, 0, 8, 4, 4, 4);
    tab[3] = mk(20, 0, 0,  0, 2,  4, 32'hE4E4E4E4, 32'h000000E4, 0, 0, 0, 5, 5, 5, 5);
    tab[4] = mk( 1, 1, 0,  0, 1,  1, 32'h00000003, 0, 0, 0, 0, 0, 0, 0, 1);
    tab[5] = mk(80, 3, 100, 64, 5, 16, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF,
                32'h00000000, 32'h55555555, 16, 32, 16, 16);
    tab[6] = mk(17, 1, 0,  0, 2,  1, 32'hFFFFFFFF, 32'h00000003, 0, 0, 0, 0, 0, 0, 17);

    reset = 1'b1;
    #3 reset = 1'b0;
    #4;
    chk("rst_ctrl", 64'({base_ready, word_valid, word_last, word_nbases, busy, done}), 64'd0);
    chk("rst_data", 64'(word_data), 64'd0);
    chk("rst_cnt", {cnt_a, cnt_c, cnt_g, cnt_t}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    foreach (tab[i]) run_seq(tab[i]);

    // Zero-length sequence: straight to DONE, no words.
    @(posedge clk); #1 start = 1'b1; seq_len = '0; word_ready = 1'b1;
    done_at = -1; nvalid = 0; nbusy = 0; idx = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) begin idx++; done_at = n; end
      if (word_valid) nvalid++;
      if (busy) nbusy++;
      @(posedge clk); #1 start = 1'b0;
    end
    chk("len0_done_cnt", 64'(idx), 64'd1);
    chk("len0_done_at", 64'(done_at inside {[1:2]}), 64'd1);
    chk("len0_no_word", 64'(nvalid + nbusy), 64'd0);

    // Reset mid-sequence after 10 of 40 bases.
    @(posedge clk); #1 start = 1'b1; seq_len = 16'd40; word_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0; idx = 0; base_valid = 1'b1; base = base_of(0, 0);
    for (int n = 0; n < 60 && idx < 10; n++) begin
      @(negedge clk);
      if (base_valid && base_ready) idx++;
      @(posedge clk); #1;
      base_valid = (idx < 10); base = base_of(0, idx);
    end
    chk("mid_bases", 64'(idx), 64'd10);
    reset = 1'b0; base_valid = 1'b0;
    #1;
    chk("mid_rst_ctrl", 64'({base_ready, word_valid, word_last, word_nbases, busy, done}), 64'd0);
    chk("mid_rst_data", 64'(word_data), 64'd0);
    chk("mid_rst_cnt", {cnt_a, cnt_c, cnt_g, cnt_t}, 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'({word_valid, busy, done}), 64'd0);
    run_seq(tab[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
